mux_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a shared 2:1 datapath mux on the 16-bit processor's internal bus. It grants one of two valid/ready sources at a time and drives the mux `Selector` from a registered grant. It captures the selected word into a single output register with a valid/ready handshake. Round-robin fairness is enforced, with a bounded burst length per grant.

---
 rtl/proc16_pkg.sv | 24 ++
 rtl/mux_arbiter_mux.sv | 9 +
 rtl/mux_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc16_pkg.sv
// Shared constants and types for the 16-bit processor's bus-side blocks.
package proc16_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT0 = ST_GRANT0,
    GRANT1 = ST_GRANT1
  } state_t;

  function automatic logic [1:0] grant_of(state_t s);
    case (s)
      GRANT0:  return 2'b01;
      GRANT1:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// The team's 1-bit 2:1 mux; Selector = 0 passes I0, 1 passes I1.
module mux (
  input  logic I0,
  input  logic I1,
  input  logic Selector,
  output logic Output
);
  assign Output = Selector ? I1 : I0;
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two valid/ready sources sharing a 2:1 datapath mux,
// with a bounded burst per grant and a single registered output stage.
module mux_arbiter
  import proc16_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Data0,
  output logic             Ack0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data1,
  output logic             Ack1,
  output logic             Selector,
  output logic [1:0]       Grant,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Out_Data,
  input  logic             Out_Ready
);

  localparam int              BW        = 4;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(MAX_BURST - 1);

  state_t           state, state_nxt;
  logic [BW-1:0]    burst, burst_nxt;
  logic             last, last_nxt;
  logic             sel_nxt;
  logic [1:0]       grant_nxt;
  logic             free;
  logic [WIDTH-1:0] mux_out;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux u_mux (
      .I0      (Data0[i]),
      .I1      (Data1[i]),
      .Selector(Selector),
      .Output  (mux_out[i])
    );
  end

  assign free = !Out_Valid || Out_Ready;
  assign Ack0 = Grant[0] && Req0 && free;
  assign Ack1 = Grant[1] && Req1 && free;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst;
    case (state)
      IDLE: begin
        if (Req0 && Req1) state_nxt = last ? GRANT0 : GRANT1;
        else if (Req0)    state_nxt = GRANT0;
        else if (Req1)    state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!Req0) state_nxt = Req1 ? GRANT1 : IDLE;
        else if (Ack0) begin
          // At the burst limit a lone requester just restarts its count.
          if (burst == LAST_BEAT) begin
            burst_nxt = '0;
            if (Req1) state_nxt = GRANT1;
          end else begin
            burst_nxt = burst + 1'b1;
          end
        end
      end
      GRANT1: begin
        if (!Req1) state_nxt = Req0 ? GRANT0 : IDLE;
        else if (Ack1) begin
          if (burst == LAST_BEAT) begin
            burst_nxt = '0;
            if (Req0) state_nxt = GRANT0;
          end else begin
            burst_nxt = burst + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) burst_nxt = '0;
  end

  // Selector and last follow the granted index; both hold through IDLE.
  always_comb begin
    grant_nxt = grant_of(state_nxt);
    sel_nxt   = Selector;
    last_nxt  = last;
    if (state_nxt == GRANT0) begin
      sel_nxt  = 1'b0;
      last_nxt = 1'b0;
    end else if (state_nxt == GRANT1) begin
      sel_nxt  = 1'b1;
      last_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state    <= IDLE;
      burst    <= '0;
      last     <= 1'b1;
      Selector <= 1'b0;
      Grant    <= 2'b00;
    end else begin
      state    <= state_nxt;
      burst    <= burst_nxt;
      last     <= last_nxt;
      Selector <= sel_nxt;
      Grant    <= grant_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
    end else if (Ack0 || Ack1) begin
      Out_Valid <= 1'b1;
      Out_Data  <= mux_out;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: vector tables, directed corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_mux_arbiter;
  localparam int MAXB = 4;

  logic        Clock, Reset_n;
  logic        Req0, Req1, Ack0, Ack1, Selector, Out_Valid, Out_Ready;
  logic [1:0]  Grant;
  logic [15:0] Data0, Data1, Out_Data;

  int n_chk  = 0;
  int n_fail = 0;

  mux_arbiter #(.WIDTH(16), .MAX_BURST(MAXB)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Req0(Req0), .Data0(Data0), .Ack0(Ack0),
    .Req1(Req1), .Data1(Data1), .Ack1(Ack1),
    .Selector(Selector), .Grant(Grant),
    .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Ready(Out_Ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: who owns the bus (-1 = nobody), beats taken this turn.
  int          m_owner;
  int          m_beats;
  bit          m_sel, m_last, m_ov;
  logic [15:0] m_od;

  function automatic bit m_req(int n);
    return (n == 0) ? Req0 : Req1;
  endfunction

  function automatic bit m_ack(int n);
    return (m_owner == n) && m_req(n) && (!m_ov || Out_Ready);
  endfunction

  task automatic model_step();
    int nxt;
    bit a0, a1;
    if (!Reset_n) begin
      m_owner = -1; m_beats = 0; m_sel = 0; m_last = 1; m_ov = 0; m_od = '0;
      return;
    end
    a0  = m_ack(0);
    a1  = m_ack(1);
    nxt = m_owner;
    if (m_owner < 0) begin
      if (Req0 && Req1) nxt = m_last ? 0 : 1;
      else if (Req0)    nxt = 0;
      else if (Req1)    nxt = 1;
    end else if (!m_req(m_owner)) begin
      nxt = m_req(1 - m_owner) ? 1 - m_owner : -1;
    end else if (m_ack(m_owner)) begin
      m_beats++;
      if (m_beats == MAXB) begin
        m_beats = 0;
        if (m_req(1 - m_owner)) nxt = 1 - m_owner;
      end
    end
    if (nxt != m_owner) m_beats = 0;
    if (a0 || a1) begin
      m_od = a1 ? Data1 : Data0;
      m_ov = 1;
    end else if (Out_Ready) begin
      m_ov = 0;
    end
    if (nxt >= 0) begin
      m_sel  = (nxt == 1);
      m_last = (nxt == 1);
    end
    m_owner = nxt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [1:0] eg;
    eg = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
    chk({tag, ".grant"}, 32'(Grant), 32'(eg));
    chk({tag, ".sel"},   32'(Selector), 32'(m_sel));
    chk({tag, ".ack0"},  32'(Ack0), 32'(m_ack(0)));
    chk({tag, ".ack1"},  32'(Ack1), 32'(m_ack(1)));
    chk({tag, ".ov"},    32'(Out_Valid), 32'(m_ov));
    if (m_ov) chk({tag, ".od"}, 32'(Out_Data), 32'(m_od));
    chk({tag, ".ack_excl"}, 32'(Ack0 && Ack1), 32'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply(input logic r0, input logic [15:0] d0, input logic r1,
                       input logic [15:0] d1, input logic rdy);
    Req0 = r0; Data0 = d0; Req1 = r1; Data1 = d1; Out_Ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    apply(0, 16'h0, 0, 16'h0, 1);
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    logic        r0;  logic [15:0] d0;
    logic        r1;  logic [15:0] d1;
    logic        rdy;
    logic [1:0]  grant;
    logic        sel, a0, a1, ov;
    logic [15:0] od;
  } vec_t;

  vec_t vecs[$];

  // Owner of contention cycle j: idle at 0, then turns of MAXB beats alternating from source 0.
  function automatic int cont_owner(int j);
    if (j == 0) return -1;
    return ((j - 1) / MAXB) % 2;
  endfunction

  initial begin
    vec_t v;
    int   o, po;
    Reset_n = 1'b0;
    apply(0, 16'h0, 0, 16'h0, 1);

    // Single source streaming
    for (int i = 0; i < 12; i++) begin
      v = '{default: '0};
      v.rst = (i == 0);
      v.r0 = 1; v.d0 = (i == 0) ? 16'h1234 : 16'(16'h1234 + i - 1);
      v.r1 = 0; v.d1 = 16'h5555; v.rdy = 1;
      v.grant = (i >= 1) ? 2'b01 : 2'b00;
      v.a0 = (i >= 1);
      v.ov = (i >= 2);
      v.od = (i >= 2) ? 16'(16'h1234 + i - 2) : 16'h0;
      vecs.push_back(v);
    end
    // Contention: both requesting every cycle
    for (int j = 0; j < 13; j++) begin
      v = '{default: '0};
      v.rst = (j == 0);
      v.r0 = 1; v.d0 = 16'(16'hA000 + j);
      v.r1 = 1; v.d1 = 16'(16'hB000 + j);
      v.rdy = 1;
      o = cont_owner(j);
      v.grant = (o < 0) ? 2'b00 : (o == 0 ? 2'b01 : 2'b10);
      v.sel = (o == 1);
      v.a0 = (o == 0);
      v.a1 = (o == 1);
      v.ov = (j >= 2);
      if (j >= 2) begin
        po = cont_owner(j - 1);
        v.od = (po == 0) ? 16'(16'hA000 + j - 1) : 16'(16'hB000 + j - 1);
      end
      vecs.push_back(v);
    end

    // Reset: outputs quiet for 5 cycles after release
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, 16'h0, 0, 16'h0, 1);
      chk("rst.grant", 32'(Grant), 0);
      chk("rst.outs", 32'({Ack0, Ack1, Selector, Out_Valid}), 0);
      chk("rst.od", 32'(Out_Data), 0);
      tick();
    end

    // Table vectors
    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      apply(vecs[k].r0, vecs[k].d0, vecs[k].r1, vecs[k].d1, vecs[k].rdy);
      chk($sformatf("vec%0d.grant", k), 32'(Grant), 32'(vecs[k].grant));
      chk($sformatf("vec%0d.sel", k), 32'(Selector), 32'(vecs[k].sel));
      chk($sformatf("vec%0d.ack", k), 32'({Ack0, Ack1}), 32'({vecs[k].a0, vecs[k].a1}));
      chk($sformatf("vec%0d.ov", k), 32'(Out_Valid), 32'(vecs[k].ov));
      if (vecs[k].ov) chk($sformatf("vec%0d.od", k), 32'(Out_Data), 32'(vecs[k].od));
      tick();
    end

    // Backpressure with 0xBEEF held
    do_reset();
    apply(1, 16'hBEEF, 0, 16'h0, 1); chk_model("bp0"); tick();
    apply(1, 16'hBEEF, 0, 16'h0, 1); chk("bp.ack_first", 32'(Ack0), 1); chk_model("bp1"); tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 16'hC001, 0, 16'h0, 0);
      chk("bp.od_hold", 32'(Out_Data), 32'h0000BEEF);
      chk("bp.ack_low", 32'(Ack0), 0);
      chk("bp.burst", 32'(dut.burst), 1);
      chk("bp.grant", 32'(Grant), 32'b01);
      chk_model("bp_hold");
      tick();
    end
    apply(1, 16'hC002, 0, 16'h0, 1); chk("bp.resume_ack", 32'(Ack0), 1);
    chk("bp.resume_od", 32'(Out_Data), 32'h0000BEEF); chk_model("bp5"); tick();
    apply(1, 16'hC003, 0, 16'h0, 1); chk("bp.next_od", 32'(Out_Data), 32'h0000C002); chk_model("bp6"); tick();

    // Drop request after two beats while source 1 waits
    do_reset();
    apply(1, 16'h0100, 1, 16'h0200, 1); chk_model("dr0"); tick();
    apply(1, 16'h0101, 1, 16'h0201, 1); chk("dr.ack0a", 32'(Ack0), 1); chk_model("dr1"); tick();
    apply(1, 16'h0102, 1, 16'h0202, 1); chk("dr.ack0b", 32'(Ack0), 1); chk_model("dr2"); tick();
    apply(0, 16'h0103, 1, 16'h0203, 1);
    chk("dr.dead", 32'({Ack0, Ack1}), 0); chk_model("dr3"); tick();
    apply(0, 16'h0104, 1, 16'h0204, 1);
    chk("dr.grant", 32'(Grant), 32'b10); chk("dr.sel", 32'(Selector), 1);
    chk("dr.ack1", 32'(Ack1), 1); chk_model("dr4"); tick();
    apply(0, 16'h0105, 1, 16'h0205, 1); chk("dr.od", 32'(Out_Data), 32'h00000204); chk_model("dr5"); tick();

    // Reset in the middle of a source-1 burst
    do_reset();
    apply(0, 16'h0, 1, 16'h7001, 1); tick();
    apply(0, 16'h0, 1, 16'h7002, 1); chk_model("mr1"); tick();
    Reset_n = 1'b0;
    apply(0, 16'h0, 1, 16'h7003, 1);
    chk("mr.pre_ov", 32'(Out_Valid), 1); chk("mr.pre_sel", 32'(Selector), 1); tick();
    Reset_n = 1'b1;
    apply(1, 16'h8001, 1, 16'h9001, 1);
    chk("mr.ov", 32'(Out_Valid), 0); chk("mr.sel", 32'(Selector), 0);
    chk("mr.grant", 32'(Grant), 0); chk("mr.acks", 32'({Ack0, Ack1}), 0);
    chk_model("mr3"); tick();
    apply(1, 16'h8002, 1, 16'h9002, 1);
    chk("mr.src0_first", 32'(Grant), 32'b01); chk_model("mr4"); tick();

    // Randomized run against the model
    do_reset();
    Req0 = 0; Req1 = 0;
    for (int c = 0; c < 600; c++) begin
      Reset_n = ($urandom_range(0, 149) != 0);
      apply(($urandom_range(0, 3) == 0) ? ~Req0 : Req0, 16'($urandom),
            ($urandom_range(0, 3) == 0) ? ~Req1 : Req1, 16'($urandom),
            ($urandom_range(0, 3) != 0));
      if (Reset_n) chk_model("rnd");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
